// File: rtl/rr_lane_fifo_if.sv
// Handshake bundle for rr_lane_fifo: write side, read side and level flags.
interface rr_lane_fifo_if #(
   parameter int WID = 32,
   parameter int CW  = 4
);
   logic           flush;
   logic           writex;
   logic [WID-1:0] wdata;
   logic           wfull;
   logic           readx;
   logic [WID-1:0] rdata;
   logic           rempty;
   logic [CW-1:0]  count;
   logic           afull;

   modport master (
      output flush, writex, wdata, readx,
      input  wfull, rdata, rempty, count, afull
   );

   modport slave (
      input  flush, writex, wdata, readx,
      output wfull, rdata, rempty, count, afull
   );
endinterface

// File: rtl/rr_lane_fifo.sv
// Round-robin lane-interleaved FIFO. Entry k of the stream lives in lane
// k mod LANES; each lane is a small circular buffer with its own indices.
// Write and read pointers pick the lane, lane indices pick the slot.
module rr_lane_fifo #(
   parameter int WID      = 32,
   parameter int LANES    = 4,
   parameter int LDEPTH   = 2,
   parameter int AFULL_TH = LANES*LDEPTH-1
) (
   input logic           clk,
   input logic           rst,
   rr_lane_fifo_if.slave bus
);
   localparam int D  = LANES*LDEPTH;
   localparam int CW = $clog2(D+1);
   localparam int LW = $clog2(LANES);
   localparam int IW = (LDEPTH > 1) ? $clog2(LDEPTH) : 1;

   logic [WID-1:0]            r_mem [LANES][LDEPTH];
   logic [LW-1:0]             r_wptr, r_rptr;
   logic [LANES-1:0][IW-1:0]  r_widx, r_ridx;
   logic [CW-1:0]             r_count;

   logic w_full, w_empty, w_wr, w_rd;

   function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] v);
      return (v == IW'(LDEPTH-1)) ? '0 : v + IW'(1);
   endfunction

   // Flags decode the registered level only; no path from writex/readx.
   assign w_full  = (r_count == CW'(D));
   assign w_empty = (r_count == '0);
   assign w_wr    = bus.writex & ~w_full  & ~bus.flush & ~rst;
   assign w_rd    = bus.readx  & ~w_empty & ~bus.flush & ~rst;

   assign bus.wfull  = w_full;
   assign bus.rempty = w_empty;
   assign bus.afull  = (r_count >= CW'(AFULL_TH));
   assign bus.count  = r_count;
   // Stale storage is masked while empty, so the array needs no reset.
   assign bus.rdata  = w_empty ? '0 : r_mem[r_rptr][r_ridx[r_rptr]];

   // Pointer, lane-index and level update; reset and flush clear identically.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_widx  <= '0;
         r_ridx  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + LW'(1);
         if (w_rd) r_rptr <= r_rptr + LW'(1);
         for (int l = 0; l < LANES; l++) begin
            if (w_wr && r_wptr == LW'(l)) r_widx[l] <= f_inc(r_widx[l]);
            if (w_rd && r_rptr == LW'(l)) r_ridx[l] <= f_inc(r_ridx[l]);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write into the selected lane slot.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr][r_widx[r_wptr]] <= bus.wdata;
   end
endmodule

// File: tb/tb_rr_lane_fifo.sv
// Directed bench for rr_lane_fifo at default parameters (D=8, AFULL_TH=7).
module tb_rr_lane_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   rr_lane_fifo_if #(.WID(32), .CW(4)) bif ();

   rr_lane_fifo #(.WID(32), .LANES(4), .LDEPTH(2), .AFULL_TH(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply inputs, take one edge, land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bif.writex = 1'b0;
      bif.readx  = 1'b0;
      bif.flush  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d);
      bif.writex = 1'b1;
      bif.wdata  = d;
      step();
      idle();
   endtask

   initial begin
      idle();
      bif.wdata = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_count", 32'(bif.count), 0);
      chk("rst_rempty", 32'(bif.rempty), 1);
      chk("rst_wfull", 32'(bif.wfull), 0);
      chk("rst_afull", 32'(bif.afull), 0);
      chk("rst_rdata", bif.rdata, 0);

      // fill 8..15
      for (int i = 0; i < 8; i++) begin
         wr(32'(8 + i));
         chk("fill_count", 32'(bif.count), 32'(i + 1));
         chk("fill_afull", 32'(bif.afull), (i + 1 >= 7) ? 1 : 0);
         chk("fill_wfull", 32'(bif.wfull), (i == 7) ? 1 : 0);
         chk("fill_head", bif.rdata, 8);
      end
      wr(32'h99);
      chk("ovf_count", 32'(bif.count), 8);
      chk("ovf_head", bif.rdata, 8);

      // drain
      bif.readx = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", bif.rdata, 32'(8 + i));
         step();
         chk("drain_count", 32'(bif.count), 32'(7 - i));
      end
      chk("drain_rempty", 32'(bif.rempty), 1);
      chk("drain_rdata0", bif.rdata, 0);
      step();
      idle();
      chk("udf_count", 32'(bif.count), 0);
      chk("udf_rempty", 32'(bif.rempty), 1);

      // refill 20..27, then simultaneous write+read while full
      for (int i = 0; i < 8; i++) wr(32'(20 + i));
      chk("refill_wfull", 32'(bif.wfull), 1);
      bif.writex = 1'b1;
      bif.readx  = 1'b1;
      bif.wdata  = 32'hAA;
      step();
      idle();
      chk("fullrw_count", 32'(bif.count), 7);
      chk("fullrw_head", bif.rdata, 21);
      bif.readx = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk("fullrw_data", bif.rdata, 32'(21 + i));
         step();
      end
      idle();
      chk("fullrw_empty", 32'(bif.rempty), 1);

      // streaming: one prefill then write+read every cycle
      wr(32'd100);
      bif.writex = 1'b1;
      bif.readx  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bif.wdata = 32'(101 + i);
         chk("stream_data", bif.rdata, 32'(100 + i));
         step();
         chk("stream_count", 32'(bif.count), 1);
      end
      idle();
      chk("stream_last", bif.rdata, 140);
      bif.readx = 1'b1;
      step();
      idle();
      chk("stream_empty", 32'(bif.rempty), 1);

      // empty: simultaneous write+read accepts the write only
      bif.writex = 1'b1;
      bif.readx  = 1'b1;
      bif.wdata  = 32'h33;
      step();
      idle();
      chk("emptyrw_count", 32'(bif.count), 1);
      chk("emptyrw_data", bif.rdata, 32'h33);
      bif.readx = 1'b1;
      step();
      idle();

      // flush overrides write
      for (int i = 0; i < 5; i++) wr(32'(32'h40 + i));
      chk("pre_flush_count", 32'(bif.count), 5);
      bif.flush  = 1'b1;
      bif.writex = 1'b1;
      bif.wdata  = 32'hEE;
      step();
      idle();
      chk("flush_count", 32'(bif.count), 0);
      chk("flush_rempty", 32'(bif.rempty), 1);
      chk("flush_rdata", bif.rdata, 0);
      wr(32'h55);
      chk("post_flush_data", bif.rdata, 32'h55);
      chk("post_flush_count", 32'(bif.count), 1);

      // reset mid-stream with readx asserted
      wr(32'h56);
      wr(32'h57);
      chk("pre_rst_count", 32'(bif.count), 3);
      rst = 1'b1;
      bif.readx = 1'b1;
      step();
      rst = 1'b0;
      idle();
      chk("mrst_count", 32'(bif.count), 0);
      chk("mrst_rempty", 32'(bif.rempty), 1);
      chk("mrst_rdata", bif.rdata, 0);
      for (int i = 0; i < 3; i++) wr(32'(32'h61 + i));
      bif.readx = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("mrst_refill", bif.rdata, 32'(32'h61 + i));
         step();
      end
      idle();
      chk("mrst_final_empty", 32'(bif.rempty), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
